// File: rtl/ram_burst_if.sv
// rtl/ram_burst_if.sv - Wishbone B4 slave bundle for the burst RAM
interface ram_burst_if #(
   parameter int WB_ADDR_BITS = 32,
   parameter int WORD_BYTES   = 4
);
   logic                        wbs_cyc_i;
   logic                        wbs_stb_i;
   logic [WB_ADDR_BITS-1:2]     wbs_addr_i;
   logic [2:0]                  wbs_cti_i;
   logic [1:0]                  wbs_bte_i;
   logic [WORD_BYTES-1:0]       wbs_sel_i;
   logic                        wbs_we_i;
   logic [8*WORD_BYTES-1:0]     wbs_data_i;
   logic [8*WORD_BYTES-1:0]     wbs_data_o;
   logic                        wbs_ack_o;
   logic                        wbs_err_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_addr_i, wbs_cti_i, wbs_bte_i,
             wbs_sel_i, wbs_we_i, wbs_data_i,
      output wbs_data_o, wbs_ack_o, wbs_err_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_addr_i, wbs_cti_i, wbs_bte_i,
             wbs_sel_i, wbs_we_i, wbs_data_i,
      input  wbs_data_o, wbs_ack_o, wbs_err_o
   );
endinterface

// File: rtl/ram_burst.sv
// rtl/ram_burst.sv - zero-wait-state Wishbone B4 burst RAM with byte lanes and range error
module ram_burst #(
   parameter int ADDR_BITS    = 12,
   parameter int WB_ADDR_BITS = 32,
   parameter logic [WB_ADDR_BITS-ADDR_BITS-1:0] HIGH_ADDR = '0,
   parameter int WORD_BYTES   = 4
) (
   input  logic           wbs_clk_i,
   input  logic           wbs_rst_n_i,
   ram_burst_if.slave     bus
);
   localparam int WORD_BITS = 8 * WORD_BYTES;
   localparam int AW        = ADDR_BITS - 2;
   localparam int DEPTH     = 1 << AW;
   localparam logic [AW-1:0] ONE    = AW'(1);
   localparam logic [AW-1:0] MASK4  = AW'(3);
   localparam logic [AW-1:0] MASK8  = AW'(7);
   localparam logic [AW-1:0] MASK16 = AW'(15);

   typedef enum logic {IDLE, BURST} state_t;
   state_t state;

   logic                 sel_req, hit, is_burst, start, cont, wr_en;
   logic [AW-1:0]        idx, wrap_mask, next_idx, rd_idx;
   logic [WORD_BITS-1:0] rd_word;

   always_comb begin
      sel_req  = bus.wbs_cyc_i & bus.wbs_stb_i;
      hit      = (bus.wbs_addr_i[WB_ADDR_BITS-1:ADDR_BITS] == HIGH_ADDR);
      is_burst = (bus.wbs_cti_i == 3'b001) || (bus.wbs_cti_i == 3'b010);
      idx      = bus.wbs_addr_i[ADDR_BITS-1:2];
      case (bus.wbs_bte_i)
         2'b01:   wrap_mask = MASK4;
         2'b10:   wrap_mask = MASK8;
         2'b11:   wrap_mask = MASK16;
         default: wrap_mask = '1;
      endcase
      // Wrapping bursts only advance the low bits; linear uses an all-ones mask.
      if (bus.wbs_cti_i == 3'b001)
         next_idx = idx;
      else
         next_idx = (idx & ~wrap_mask) | ((idx + ONE) & wrap_mask);
      // Idle start is gated by the previous ack/err so each classic access leaves a gap.
      start  = (state == IDLE) && sel_req && !bus.wbs_ack_o && !bus.wbs_err_o;
      cont   = (state == BURST) && sel_req && hit;
      wr_en  = ((start && hit) || cont) && bus.wbs_we_i;
      rd_idx = (state == IDLE) ? idx : next_idx;
   end

   for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge wbs_clk_i) begin
         if (wr_en && bus.wbs_sel_i[i])
            mem[idx] <= bus.wbs_data_i[8*i +: 8];
      end

      assign rd_word[8*i +: 8] = mem[rd_idx];
   end

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         state          <= IDLE;
         bus.wbs_ack_o  <= 1'b0;
         bus.wbs_err_o  <= 1'b0;
         bus.wbs_data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.wbs_ack_o <= 1'b0;
               bus.wbs_err_o <= 1'b0;
               if (start) begin
                  if (hit) begin
                     bus.wbs_ack_o <= 1'b1;
                     if (!bus.wbs_we_i)
                        bus.wbs_data_o <= rd_word;
                     if (is_burst)
                        state <= BURST;
                  end else begin
                     bus.wbs_err_o <= 1'b1;
                  end
               end
            end
            BURST: begin
               if (!sel_req) begin
                  bus.wbs_ack_o <= 1'b0;
                  state         <= IDLE;
               end else if (!hit) begin
                  bus.wbs_ack_o <= 1'b0;
                  bus.wbs_err_o <= 1'b1;
                  state         <= IDLE;
               end else if (is_burst) begin
                  bus.wbs_ack_o <= 1'b1;
                  if (!bus.wbs_we_i)
                     bus.wbs_data_o <= rd_word;
               end else begin
                  bus.wbs_ack_o <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_burst.sv
// tb/tb_ram_burst.sv - directed self-checking bench for ram_burst
module tb_ram_burst;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passed = 0;

   ram_burst_if bus ();

   ram_burst dut (
      .wbs_clk_i   (clk),
      .wbs_rst_n_i (rst_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.wbs_cyc_i  = 1'b0;
      bus.wbs_stb_i  = 1'b0;
      bus.wbs_we_i   = 1'b0;
      bus.wbs_cti_i  = 3'b000;
      bus.wbs_bte_i  = 2'b00;
      bus.wbs_sel_i  = 4'hF;
      bus.wbs_addr_i = '0;
      bus.wbs_data_i = '0;
   endtask

   task automatic drive(input logic [29:0] a, input logic we, input logic [2:0] cti,
                        input logic [1:0] bte, input logic [3:0] sel, input logic [31:0] d);
      bus.wbs_cyc_i  = 1'b1;
      bus.wbs_stb_i  = 1'b1;
      bus.wbs_addr_i = a;
      bus.wbs_we_i   = we;
      bus.wbs_cti_i  = cti;
      bus.wbs_bte_i  = bte;
      bus.wbs_sel_i  = sel;
      bus.wbs_data_i = d;
   endtask

   task automatic classic_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] sel);
      drive(a, 1'b1, 3'b000, 2'b00, sel, d);
      tick();
      chk("wr_ack", 32'(bus.wbs_ack_o), 32'd1);
      bus_idle();
      tick();
   endtask

   task automatic classic_read(input string tag, input logic [29:0] a, input logic [31:0] exp);
      drive(a, 1'b0, 3'b000, 2'b00, 4'hF, 32'h0);
      tick();
      chk({tag, "_ack"}, 32'(bus.wbs_ack_o), 32'd1);
      chk(tag, bus.wbs_data_o, exp);
      bus_idle();
      tick();
   endtask

   initial begin
      bus_idle();
      #12;
      chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
      chk("rst_err", 32'(bus.wbs_err_o), 32'd0);
      chk("rst_data", bus.wbs_data_o, 32'd0);
      rst_n = 1'b1;
      tick();

      // preload words 0..7
      classic_write(30'd0, 32'h11, 4'hF);
      classic_write(30'd1, 32'h22, 4'hF);
      classic_write(30'd2, 32'h33, 4'hF);
      classic_write(30'd3, 32'h44, 4'hF);
      classic_write(30'd4, 32'h55, 4'hF);
      classic_write(30'd5, 32'h66, 4'hF);
      classic_write(30'd6, 32'h77, 4'hF);
      classic_write(30'd7, 32'h88, 4'hF);

      // classic write then held-strobe read: ack one cycle, then a forced gap
      classic_write(30'd16, 32'hDEADBEEF, 4'hF);
      drive(30'd16, 1'b0, 3'b000, 2'b00, 4'b0011, 32'h0);
      tick();
      chk("cls_ack", 32'(bus.wbs_ack_o), 32'd1);
      chk("cls_data", bus.wbs_data_o, 32'hDEADBEEF);
      tick();
      chk("cls_gap", 32'(bus.wbs_ack_o), 32'd0);
      bus_idle();
      tick();

      // linear incrementing burst read 0..3
      drive(30'd0, 1'b0, 3'b010, 2'b00, 4'hF, 32'h0);
      tick();
      chk("lin_ack0", 32'(bus.wbs_ack_o), 32'd1);
      chk("lin_d0", bus.wbs_data_o, 32'h11);
      tick();
      chk("lin_ack1", 32'(bus.wbs_ack_o), 32'd1);
      chk("lin_d1", bus.wbs_data_o, 32'h22);
      bus.wbs_addr_i = 30'd1;
      tick();
      chk("lin_d2", bus.wbs_data_o, 32'h33);
      bus.wbs_addr_i = 30'd2;
      tick();
      chk("lin_ack3", 32'(bus.wbs_ack_o), 32'd1);
      chk("lin_d3", bus.wbs_data_o, 32'h44);
      bus.wbs_addr_i = 30'd3;
      bus.wbs_cti_i  = 3'b111;
      tick();
      chk("lin_end", 32'(bus.wbs_ack_o), 32'd0);
      bus_idle();
      tick();

      // wrap-4 burst read from word 6: 6,7,4,5
      drive(30'd6, 1'b0, 3'b010, 2'b01, 4'hF, 32'h0);
      tick();
      chk("w4_d6", bus.wbs_data_o, 32'h77);
      tick();
      chk("w4_d7", bus.wbs_data_o, 32'h88);
      bus.wbs_addr_i = 30'd7;
      tick();
      chk("w4_ack4", 32'(bus.wbs_ack_o), 32'd1);
      chk("w4_d4", bus.wbs_data_o, 32'h55);
      bus.wbs_addr_i = 30'd4;
      tick();
      chk("w4_d5", bus.wbs_data_o, 32'h66);
      bus.wbs_addr_i = 30'd5;
      bus.wbs_cti_i  = 3'b111;
      tick();
      chk("w4_end", 32'(bus.wbs_ack_o), 32'd0);
      bus_idle();
      tick();

      // wrap-4 burst write with sel=0101 into words 6,7
      drive(30'd6, 1'b1, 3'b010, 2'b01, 4'b0101, 32'hAABBCCDD);
      tick();
      chk("bw_ack0", 32'(bus.wbs_ack_o), 32'd1);
      tick();
      chk("bw_ack1", 32'(bus.wbs_ack_o), 32'd1);
      bus.wbs_addr_i = 30'd7;
      bus.wbs_data_i = 32'h11223344;
      bus.wbs_cti_i  = 3'b111;
      tick();
      chk("bw_end", 32'(bus.wbs_ack_o), 32'd0);
      bus_idle();
      tick();
      classic_read("bw_rd6", 30'd6, 32'h00BB00DD);
      classic_read("bw_rd7", 30'd7, 32'h00220044);

      // out-of-range write held four cycles: err alternates, nothing written
      drive({20'h00001, 10'd3}, 1'b1, 3'b000, 2'b00, 4'hF, 32'hFFFFFFFF);
      tick();
      chk("oor_err0", 32'(bus.wbs_err_o), 32'd1);
      chk("oor_ack0", 32'(bus.wbs_ack_o), 32'd0);
      tick();
      chk("oor_err1", 32'(bus.wbs_err_o), 32'd0);
      tick();
      chk("oor_err2", 32'(bus.wbs_err_o), 32'd1);
      chk("oor_ack2", 32'(bus.wbs_ack_o), 32'd0);
      tick();
      chk("oor_err3", 32'(bus.wbs_err_o), 32'd0);
      bus_idle();
      tick();
      classic_read("oor_mem", 30'd3, 32'h44);

      // burst stall: strobe low for two cycles, resume costs one cycle
      drive(30'd0, 1'b0, 3'b010, 2'b00, 4'hF, 32'h0);
      tick();
      chk("st_d0", bus.wbs_data_o, 32'h11);
      tick();
      chk("st_d1", bus.wbs_data_o, 32'h22);
      bus.wbs_addr_i = 30'd1;
      bus.wbs_stb_i  = 1'b0;
      tick();
      chk("st_drop", 32'(bus.wbs_ack_o), 32'd0);
      tick();
      chk("st_hold", 32'(bus.wbs_ack_o), 32'd0);
      bus.wbs_stb_i = 1'b1;
      tick();
      chk("st_res_ack", 32'(bus.wbs_ack_o), 32'd1);
      chk("st_res_d", bus.wbs_data_o, 32'h22);
      tick();
      chk("st_d2", bus.wbs_data_o, 32'h33);
      bus.wbs_addr_i = 30'd2;
      bus.wbs_cti_i  = 3'b111;
      tick();
      chk("st_end", 32'(bus.wbs_ack_o), 32'd0);
      bus_idle();
      tick();

      // reset during beat 2 of a read burst
      drive(30'd0, 1'b0, 3'b010, 2'b00, 4'hF, 32'h0);
      tick();
      tick();
      bus.wbs_addr_i = 30'd1;
      rst_n = 1'b0;
      #2;
      chk("mrst_ack", 32'(bus.wbs_ack_o), 32'd0);
      chk("mrst_err", 32'(bus.wbs_err_o), 32'd0);
      chk("mrst_data", bus.wbs_data_o, 32'd0);
      bus_idle();
      tick();
      rst_n = 1'b1;
      tick();
      classic_read("mrst_rd4", 30'd4, 32'h55);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
